// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : Multi-digit seven-segment overlay renderer. A binary value is
//            sampled on `load`, saturated to DIGITS decimal digits, converted
//            to BCD by a sequential double-dabble engine and painted as
//            DIGITS glyphs side by side. Supports leading-zero blanking and
//            frame-synchronous blinking. The colour output is meant to be
//            ORed into the pixel mux.
// Ports    : clk        - pixel clock
//            rst        - synchronous active-high reset
//            x, y       - current pixel column / row
//            value      - binary number to display
//            load       - single-cycle strobe sampling `value` (ignored while busy)
//            blank_lead - suppress leading zeros (last digit always shown)
//            blink_en   - blank the output during the odd blink phase
//            frame_tick - one-cycle pulse per frame, drives the blink timer
//            busy       - conversion in progress
//            color      - registered pixel colour, one cycle after x/y
// Revision : 1.0 - initial release
// ============================================================================
module score_display #(
  parameter int         DIGITS       = 4,
  parameter int         VALUE_W      = 14,
  parameter int         BASE_X       = 100,
  parameter int         BASE_Y       = 100,
  parameter int         THICK        = 30,
  parameter int         H_LEN        = 90,
  parameter int         V_LEN        = 155,
  parameter int         PITCH        = 180,
  parameter logic [5:0] COLOR_ON     = 6'b100111,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        x,
  input  logic [9:0]         y,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lead,
  input  logic               blink_en,
  input  logic               frame_tick,
  output logic               busy,
  output logic [5:0]         color
);

  localparam int SR_W  = 4 * DIGITS + VALUE_W;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Largest displayable value, 10^DIGITS - 1.
  function automatic logic [63:0] sat_limit(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction
  localparam logic [63:0] SAT_MAX = sat_limit(DIGITS);

  // Glyph bits ordered {UL, LL, top, mid, bottom, UR, LR}.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1110111;
      4'd1:    return 7'b0000011;
      4'd2:    return 7'b0111110;
      4'd3:    return 7'b0011111;
      4'd4:    return 7'b1001011;
      4'd5:    return 7'b1011101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0010011;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1011111;
      default: return 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [SR_W-1:0]    sr_adj;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               busy_q, busy_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [5:0]         color_q, color_d;
  logic [VALUE_W-1:0] sat_value;

  // Converter: the shift register holds {bcd scratch, binary remainder}.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    step_d    = step_q;
    disp_d    = disp_q;
    sat_value = (64'(value) > SAT_MAX) ? SAT_MAX[VALUE_W-1:0] : value;
    sr_adj    = sr_q;
    for (int n = 0; n < DIGITS; n++) begin
      if (sr_adj[VALUE_W + 4*n +: 4] >= 4'd5)
        sr_adj[VALUE_W + 4*n +: 4] = sr_adj[VALUE_W + 4*n +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d    = {{BCD_W{1'b0}}, sat_value};
          step_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        step_d = step_q + CNT_W'(1);
        if (step_q == CNT_W'(VALUE_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_d  = sr_q[SR_W-1 -: BCD_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Blink timer runs whether or not blinking is enabled.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Geometry is evaluated at 12 bits so offsets past the screen never wrap.
  logic [11:0] x12, y12;
  assign x12 = {1'b0, x};
  assign y12 = {2'b0, y};

  localparam logic [11:0] Y0 = 12'(BASE_Y);
  localparam logic [11:0] Y1 = 12'(BASE_Y + THICK);
  localparam logic [11:0] Y2 = 12'(BASE_Y + THICK + V_LEN);
  localparam logic [11:0] Y3 = 12'(BASE_Y + 2*THICK + V_LEN);
  localparam logic [11:0] Y4 = 12'(BASE_Y + 2*THICK + 2*V_LEN);
  localparam logic [11:0] Y5 = 12'(BASE_Y + 3*THICK + 2*V_LEN);

  logic in_top, in_up, in_mid, in_lo, in_bot;
  assign in_top = (y12 >= Y0) && (y12 < Y1);
  assign in_up  = (y12 >= Y1) && (y12 < Y2);
  assign in_mid = (y12 >= Y2) && (y12 < Y3);
  assign in_lo  = (y12 >= Y3) && (y12 < Y4);
  assign in_bot = (y12 >= Y4) && (y12 < Y5);

  // A digit is dark while every digit from the left up to it is zero,
  // except the rightmost, which always shows.
  logic [DIGITS-1:0] dark;
  logic              zero_run;
  always_comb begin
    zero_run = 1'b1;
    dark     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (disp_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      dark[i]  = blank_lead & zero_run & (i != DIGITS - 1);
    end
  end

  logic [DIGITS-1:0] lit;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam int          BX = BASE_X + gi * PITCH;
    localparam logic [11:0] X0 = 12'(BX);
    localparam logic [11:0] X1 = 12'(BX + THICK);
    localparam logic [11:0] X2 = 12'(BX + THICK + H_LEN);
    localparam logic [11:0] X3 = 12'(BX + 2*THICK + H_LEN);
    logic       in_l, in_m, in_r;
    logic [6:0] hit;
    assign in_l = (x12 >= X0) && (x12 < X1);
    assign in_m = (x12 >= X1) && (x12 < X2);
    assign in_r = (x12 >= X2) && (x12 < X3);
    assign hit  = {in_l & in_up, in_l & in_lo, in_m & in_top, in_m & in_mid,
                   in_m & in_bot, in_r & in_up, in_r & in_lo};
    assign lit[gi] = (|(hit & seg_decode(disp_q[4*(DIGITS-1-gi) +: 4]))) & ~dark[gi];
  end

  always_comb begin
    color_d = ((|lit) && !(blink_en && phase_q)) ? COLOR_ON : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      step_q      <= '0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      color_q     <= 6'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      step_q      <= step_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      color_q     <= color_d;
    end
  end

  assign busy  = busy_q;
  assign color = color_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
module tb_score_display;
  localparam int         VW  = 14;
  localparam logic [5:0] ON  = 6'b100111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   x = '0;
  logic [9:0]    y = '0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0, blank_lead = 1'b0, blink_en = 1'b0, frame_tick = 1'b0;
  logic          busy_a, busy_b;
  logic [5:0]    color_a, color_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_display u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .value(value), .load(load),
    .blank_lead(blank_lead), .blink_en(blink_en), .frame_tick(frame_tick),
    .busy(busy_a), .color(color_a)
  );

  score_display #(.BLINK_FRAMES(2)) u_blk (
    .clk(clk), .rst(rst), .x(x), .y(y), .value(value), .load(load),
    .blank_lead(blank_lead), .blink_en(blink_en), .frame_tick(frame_tick),
    .busy(busy_b), .color(color_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Standard glyphs by segment letter (a top, b UR, c LR, d bottom, e LL, f UL, g mid).
  function automatic bit glyph_has(input int d, input byte s);
    string g;
    case (d)
      0: g = "abcdef";  1: g = "bc";      2: g = "abdeg";  3: g = "abcdg";
      4: g = "bcfg";    5: g = "acdfg";   6: g = "acdefg"; 7: g = "abc";
      8: g = "abcdefg"; default: g = "abcdfg";
    endcase
    for (int i = 0; i < g.len(); i++) if (g[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic byte seg_at(input int px, input int py, input int bx);
    int rx, ry;
    byte col, row;
    rx = px - bx; ry = py - 100;
    col = (rx >= 0 && rx < 30) ? "L" : (rx >= 30 && rx < 120) ? "M" :
          (rx >= 120 && rx < 150) ? "R" : 8'd0;
    row = (ry >= 0 && ry < 30) ? "t" : (ry >= 30 && ry < 185) ? "u" :
          (ry >= 185 && ry < 215) ? "m" : (ry >= 215 && ry < 370) ? "l" :
          (ry >= 370 && ry < 400) ? "b" : 8'd0;
    if (col == "L" && row == "u") return "f";
    if (col == "L" && row == "l") return "e";
    if (col == "M" && row == "t") return "a";
    if (col == "M" && row == "m") return "g";
    if (col == "M" && row == "b") return "d";
    if (col == "R" && row == "u") return "b";
    if (col == "R" && row == "l") return "c";
    return 8'd0;
  endfunction

  function automatic logic [5:0] model_pix(input int px, input int py, input int disp, input bit bl);
    int  d[4];
    bit  all_zero;
    byte s;
    d[0] = disp / 1000; d[1] = (disp / 100) % 10; d[2] = (disp / 10) % 10; d[3] = disp % 10;
    all_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      all_zero = all_zero && (d[i] == 0);
      s = seg_at(px, py, 100 + 180 * i);
      if (s != 0 && !(bl && all_zero && i < 3) && glyph_has(d[i], s)) return ON;
    end
    return 6'd0;
  endfunction

  int         m_disp = 0, m_pend = 0, m_cd = 0, m_cnt_a = 0, m_cnt_b = 0;
  bit         m_ph_a = 0, m_ph_b = 0, model_ok = 0, exp_busy = 0;
  logic [5:0] exp_col_a = '0, exp_col_b = '0;

  always @(posedge clk) begin
    logic [5:0] pix;
    pix = model_pix(int'(x), int'(y), m_disp, blank_lead);
    if (rst) begin
      exp_col_a = 0; exp_col_b = 0; m_disp = 0; m_cd = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_ph_a = 0; m_ph_b = 0;
      exp_busy = 0; model_ok = 1;
    end else begin
      exp_col_a = (blink_en && m_ph_a) ? 6'd0 : pix;
      exp_col_b = (blink_en && m_ph_b) ? 6'd0 : pix;
      if (frame_tick) begin
        m_cnt_a++; if (m_cnt_a == 30) begin m_cnt_a = 0; m_ph_a = !m_ph_a; end
        m_cnt_b++; if (m_cnt_b == 2)  begin m_cnt_b = 0; m_ph_b = !m_ph_b; end
      end
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_disp = m_pend;
      end else if (load) begin
        m_pend = (int'(value) > 9999) ? 9999 : int'(value);
        m_cd   = VW + 1;
      end
      exp_busy = (m_cd > 0);
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      chk("busy_a", int'(busy_a), int'(exp_busy));
      chk("busy_b", int'(busy_b), int'(exp_busy));
      chk("color_a", int'(color_a), int'(exp_col_a));
      chk("color_b", int'(color_b), int'(exp_col_b));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic do_load(input int v);
    value = VW'(v); load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_a && n < 100) begin step(); n++; end
    if (n >= 100) chk("wait_idle_timeout", 1, 0);
    step();
  endtask

  task automatic pix(input string nm, input int px, input int py, input int exp);
    x = 11'(px); y = 10'(py);
    step();
    chk(nm, int'(color_a), exp);
  endtask

  initial begin
    int n, falls;
    bit prev;
    int blink_exp[6];
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_busy", int'(busy_a), 0);
    pix("reset_digit3_top", 670, 110, ON);
    pix("reset_gap", 260, 110, 0);

    // 1234: busy width and glyph pixels
    do_load(1234);
    n = 0;
    for (int i = 0; i < 40; i++) begin if (busy_a) n++; step(); end
    chk("busy_cycles", n, 15);
    pix("d0_seg1_1234", 235, 200, ON);
    pix("d0_seg6_1234", 115, 200, 0);
    pix("d1_top_1234", 310, 110, ON);

    // saturation to 9999
    do_load(12000);
    wait_idle();
    pix("d2_mid_9999", 520, 300, ON);
    pix("corner_9999", 420, 300, 0);
    pix("d0_top_9999", 130, 110, ON);

    // leading-zero blanking of 0
    blank_lead = 1'b1;
    do_load(0);
    wait_idle();
    pix("blank_d0_top", 130, 110, 0);
    pix("blank_d2_top", 490, 110, 0);
    pix("blank_d3_top", 670, 110, ON);
    pix("blank_d3_mid", 670, 300, 0);

    // load while busy is ignored
    do_load(5);
    step();
    value = VW'(7); load = 1'b1; step(); load = 1'b0;
    falls = 0; prev = busy_a;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev && !busy_a) falls++;
      prev = busy_a;
    end
    chk("busy_falls", falls, 1);
    pix("five_d3_ul", 645, 200, ON);
    pix("five_d3_ur", 775, 200, 0);
    pix("five_d0_dark", 130, 110, 0);

    // blinking on the BLINK_FRAMES=2 instance
    blank_lead = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    x = 11'd670; y = 10'd110; blink_en = 1'b1;
    step(); step();
    chk("blink_initial", int'(color_b), int'(ON));
    blink_exp = '{int'(ON), 0, 0, int'(ON), int'(ON), 0};
    for (int t = 0; t < 6; t++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      step(); step();
      chk("blink_tick", int'(color_b), blink_exp[t]);
    end
    chk("blink_slow_lit", int'(color_a), int'(ON));
    blink_en = 1'b0;

    // reset in the middle of a conversion
    do_load(4321);
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_busy", int'(busy_a), 0);
    repeat (20) step();
    chk("rst_mid_idle", int'(busy_a), 0);
    pix("rst_d3_top", 670, 110, ON);
    pix("rst_d0_ur", 235, 200, ON);
    pix("rst_d1_mid", 310, 300, 0);
    pix("rst_d0_top", 130, 110, ON);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
